// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module : cpu_sequencer
// Multi-cycle fetch/decode/exec/mem/writeback controller for an external ALU.
// Rev    : 1.0  initial release
// ============================================================================
module cpu_sequencer #(
    parameter logic [7:0] RESET_PC    = 8'h00,
    parameter int         MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       imem_req,
    output logic [7:0] imem_addr,
    input  logic [7:0] imem_rdata,
    input  logic       imem_valid,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic [7:0] dmem_addr,
    output logic [7:0] dmem_wdata,
    input  logic [7:0] dmem_rdata,
    input  logic       dmem_ack,
    output logic [7:0] alu_instruction,
    output logic [7:0] alu_pc,
    output logic [7:0] alu_in0,
    output logic [7:0] alu_in1,
    input  logic [7:0] alu_out,
    input  logic [7:0] alu_jump,
    input  logic       alu_overflow,
    output logic [7:0] pc,
    output logic       busy,
    output logic       halted,
    output logic       error,
    output logic       ovf_sticky
);

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
    localparam logic [2:0] ST_HALT   = 3'd6;
    localparam logic [2:0] ST_ERROR  = 3'd7;

    logic [2:0]        state_q, state_d;
    logic [7:0]        pc_q, pc_d;
    logic [7:0]        ir_q, ir_d;
    logic [7:0]        rf_q [4];
    logic [7:0]        rf_d [4];
    logic [7:0]        ins_q, ins_d;
    logic [7:0]        apc_q, apc_d;
    logic [7:0]        in0_q, in0_d;
    logic [7:0]        in1_q, in1_d;
    logic [7:0]        res_q, res_d;
    logic [7:0]        jmp_q, jmp_d;
    logic [7:0]        ld_q, ld_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              ovf_q, ovf_d;

    logic [3:0] w_op;
    logic [1:0] w_ra;
    logic [1:0] w_rb;
    logic       w_is_mem;
    logic       w_is_store;
    logic       w_timeout;
    logic [7:0] w_pc_inc;
    logic [7:0] w_pc_next;

    assign w_op       = ir_q[7:4];
    assign w_ra       = ir_q[3:2];
    assign w_rb       = ir_q[1:0];
    assign w_is_mem   = (w_op == 4'hA) || (w_op == 4'hB);
    assign w_is_store = (w_op == 4'hB);
    assign w_timeout  = (wait_q == WAIT_W'(MEM_TIMEOUT - 1));
    assign w_pc_inc   = pc_q + 8'd1;

    // R3 is only written in WB, so reading it here equals the DECODE-time value.
    always_comb begin
        w_pc_next = w_pc_inc;
        case (w_op)
            4'h8, 4'h9: w_pc_next = w_pc_inc + res_q;
            4'hC, 4'hD: if (jmp_q == 8'hFF) w_pc_next = rf_q[3];
            default:    w_pc_next = w_pc_inc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_FETCH;
            ST_FETCH: begin
                if (imem_valid)     state_d = ST_DECODE;
                else if (w_timeout) state_d = ST_ERROR;
            end
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC:   state_d = w_is_mem ? ST_MEM : ST_WB;
            ST_MEM: begin
                if (dmem_ack)       state_d = ST_WB;
                else if (w_timeout) state_d = ST_ERROR;
            end
            ST_WB:     state_d = (w_pc_next == pc_q) ? ST_HALT : ST_FETCH;
            ST_HALT:   state_d = ST_HALT;
            ST_ERROR:  state_d = ST_ERROR;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        imem_req   = (state_q == ST_FETCH);
        dmem_req   = (state_q == ST_MEM);
        dmem_we    = (state_q == ST_MEM) && w_is_store;
        dmem_addr  = (state_q == ST_MEM) ? in1_q : 8'h00;
        dmem_wdata = ((state_q == ST_MEM) && w_is_store) ? in0_q : 8'h00;
        busy       = (state_q != ST_IDLE) && (state_q != ST_HALT) && (state_q != ST_ERROR);
        halted     = (state_q == ST_HALT);
        error      = (state_q == ST_ERROR);
    end

    assign imem_addr       = pc_q;
    assign pc              = pc_q;
    assign alu_instruction = ins_q;
    assign alu_pc          = apc_q;
    assign alu_in0         = in0_q;
    assign alu_in1         = in1_q;
    assign ovf_sticky      = ovf_q;

    always_comb begin
        pc_d  = pc_q;
        ir_d  = ir_q;
        ins_d = ins_q;
        apc_d = apc_q;
        in0_d = in0_q;
        in1_d = in1_q;
        res_d = res_q;
        jmp_d = jmp_q;
        ld_d  = ld_q;
        ovf_d = ovf_q;
        wait_d = '0;
        for (int i = 0; i < 4; i++) rf_d[i] = rf_q[i];

        case (state_q)
            ST_FETCH: begin
                if (imem_valid)      ir_d   = imem_rdata;
                else if (!w_timeout) wait_d = wait_q + WAIT_W'(1);
            end
            ST_DECODE: begin
                ins_d = ir_q;
                in0_d = rf_q[w_ra];
                in1_d = rf_q[w_rb];
                apc_d = pc_q;
            end
            ST_EXEC: begin
                res_d = alu_out;
                jmp_d = alu_jump;
                if (w_op == 4'h1) ovf_d = ovf_q | alu_overflow;
            end
            ST_MEM: begin
                if (dmem_ack) begin
                    if (!w_is_store) ld_d = dmem_rdata;
                end else if (!w_timeout) begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_WB: begin
                case (w_op)
                    4'h0, 4'h1, 4'h2, 4'h3,
                    4'h4, 4'h5, 4'h6, 4'h7,
                    4'hE, 4'hF: rf_d[w_ra] = res_q;
                    4'hA:       rf_d[w_ra] = ld_q;
                    4'h9:       rf_d[3]    = w_pc_inc;
                    default:    ;
                endcase
                pc_d = w_pc_next;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q   <= RESET_PC;
            ir_q   <= 8'h00;
            ins_q  <= 8'h00;
            apc_q  <= 8'h00;
            in0_q  <= 8'h00;
            in1_q  <= 8'h00;
            res_q  <= 8'h00;
            jmp_q  <= 8'h00;
            ld_q   <= 8'h00;
            ovf_q  <= 1'b0;
            wait_q <= '0;
            for (int i = 0; i < 4; i++) rf_q[i] <= 8'h00;
        end else begin
            pc_q   <= pc_d;
            ir_q   <= ir_d;
            ins_q  <= ins_d;
            apc_q  <= apc_d;
            in0_q  <= in0_d;
            in1_q  <= in1_d;
            res_q  <= res_d;
            jmp_q  <= jmp_d;
            ld_q   <= ld_d;
            ovf_q  <= ovf_d;
            wait_q <= wait_d;
            for (int i = 0; i < 4; i++) rf_q[i] <= rf_d[i];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : tb_cpu_sequencer
// Self-checking bench: directed scenarios plus random programs vs an ISA model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_cpu_sequencer;

    localparam logic [7:0] RESET_PC    = 8'h00;
    localparam int         MEM_TIMEOUT = 16;

    logic       clk, reset, start;
    logic       imem_req, imem_valid, dmem_req, dmem_we, dmem_ack;
    logic [7:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata;
    logic [7:0] alu_instruction, alu_pc, alu_in0, alu_in1, alu_out, alu_jump;
    logic       alu_overflow;
    logic [7:0] pc;
    logic       busy, halted, error, ovf_sticky;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] prog [256];
    logic [7:0] dmem [256];
    int idelay, ddelay, dead_addr, icnt, dcnt;

    logic [7:0] mR [4];
    logic [7:0] mmem [256];
    logic [7:0] mpc;
    logic       movf;

    cpu_sequencer #(.RESET_PC(RESET_PC), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .reset(reset), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .alu_instruction(alu_instruction), .alu_pc(alu_pc), .alu_in0(alu_in0), .alu_in1(alu_in1),
        .alu_out(alu_out), .alu_jump(alu_jump), .alu_overflow(alu_overflow),
        .pc(pc), .busy(busy), .halted(halted), .error(error), .ovf_sticky(ovf_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU: returns {overflow, jump, result}; jump is deliberately noisy for non-branch ops.
    function automatic logic [16:0] alu_fn(input logic [7:0] ins, input logic [7:0] a,
                                           input logic [7:0] b, input logic [7:0] p);
        logic [7:0] o, j;
        logic v;
        o = 8'h00; v = 1'b0; j = a[0] ? 8'hFF : 8'h00;
        case (ins[7:4])
            4'h0: o = b;
            4'h1: begin o = a + b; v = (a[7] == b[7]) && (o[7] != a[7]); end
            4'h2: begin o = a - b; v = (a[7] != b[7]) && (o[7] != a[7]); end
            4'h3: o = a & b;
            4'h4: o = a | b;
            4'h5: o = a ^ b;
            4'h6: o = ~a;
            4'h7: o = {a[6:0], 1'b0};
            4'h8, 4'h9: o = b - p - 8'd1;
            4'hA, 4'hB: o = a + b;
            4'hC: begin o = a ^ b; j = (a == b) ? 8'hFF : 8'h00; end
            4'hD: begin o = a ^ b; j = (a != b) ? 8'hFF : 8'h00; end
            4'hE: o = b + 8'd1;
            default: o = {6'b0, ins[1:0]};
        endcase
        return {v, j, o};
    endfunction

    always_comb {alu_overflow, alu_jump, alu_out} = alu_fn(alu_instruction, alu_in0, alu_in1, alu_pc);

    // Memory responders: decide the inputs for each cycle just after the clock edge.
    initial begin
        imem_valid = 1'b0; imem_rdata = 8'h00; dmem_ack = 1'b0; dmem_rdata = 8'h00;
        icnt = 0; dcnt = 0;
        forever begin
            @(posedge clk); #1;
            if (imem_req && (int'(imem_addr) != dead_addr) && icnt >= idelay) begin
                imem_valid = 1'b1; imem_rdata = prog[imem_addr];
            end else begin
                imem_valid = 1'b0; imem_rdata = 8'($urandom);
            end
            if (imem_req) icnt++; else icnt = 0;
            if (dmem_req && dcnt >= ddelay) begin
                dmem_ack = 1'b1;
                dmem_rdata = dmem_we ? 8'($urandom) : dmem[dmem_addr];
                if (dmem_we) dmem[dmem_addr] = dmem_wdata;
            end else begin
                dmem_ack = 1'b0; dmem_rdata = 8'($urandom);
            end
            if (dmem_req) dcnt++; else dcnt = 0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk); @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0;
        idelay = 0; ddelay = 0; dead_addr = -1;
        for (int i = 0; i < 256; i++) begin prog[i] = 8'h00; dmem[i] = 8'h00; end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Runs from the first FETCH cycle of one instruction to the first cycle of the next (or HALT/ERROR).
    task automatic run_instr(output int cyc);
        bit left, done;
        cyc = 0; left = 0; done = 0;
        while (!done) begin
            step();
            cyc++;
            if (!imem_req) left = 1;
            if ((left && imem_req) || halted || error || cyc >= 100) done = 1;
        end
    endtask

    task automatic model_step(input logic [7:0] ins, output int cyc_exp, output bit halt_exp);
        logic [3:0] op;
        logic [1:0] ra, rb;
        logic [7:0] a, b, o, j, npc;
        logic [16:0] r;
        op = ins[7:4]; ra = ins[3:2]; rb = ins[1:0];
        a = mR[ra]; b = mR[rb];
        r = alu_fn(ins, a, b, mpc);
        o = r[7:0]; j = r[15:8];
        if (op == 4'h1 && r[16]) movf = 1'b1;
        cyc_exp = 4 + idelay;
        npc = mpc + 8'd1;
        case (op)
            4'hA: begin mR[ra] = mmem[b]; cyc_exp += ddelay + 1; end
            4'hB: begin mmem[b] = a; cyc_exp += ddelay + 1; end
            4'h8: npc = mpc + 8'd1 + o;
            4'h9: begin mR[3] = mpc + 8'd1; npc = mpc + 8'd1 + o; end
            4'hC, 4'hD: if (j == 8'hFF) npc = mR[3];
            default: mR[ra] = o;
        endcase
        halt_exp = (npc == mpc);
        mpc = npc;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if ({imem_req, dmem_req, dmem_we, busy, halted, error, ovf_sticky} !== 7'b0)
            $display("FAIL reset_flags got %b exp 0000000", {imem_req, dmem_req, dmem_we, busy, halted, error, ovf_sticky}); else n_pass++;
        n_checks++; if (pc !== RESET_PC) $display("FAIL reset_pc got %h exp %h", pc, RESET_PC); else n_pass++;
        n_checks++; if ({alu_instruction, alu_pc, alu_in0, alu_in1, dmem_addr, dmem_wdata} !== 48'h0)
            $display("FAIL reset_buses got %h exp 0", {alu_instruction, alu_pc, alu_in0, alu_in1, dmem_addr, dmem_wdata}); else n_pass++;
        repeat (3) step();
        n_checks++; if (busy !== 1'b0 || imem_req !== 1'b0) $display("FAIL idle_wait busy=%b req=%b exp 0 0", busy, imem_req); else n_pass++;
    endtask

    task automatic test_li_add();
        int c;
        do_reset();
        prog[0] = 8'hFA; prog[1] = 8'hF5; prog[2] = 8'h16; prog[3] = 8'h04;
        start_pulse();
        n_checks++; if (busy !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 8'h00)
            $display("FAIL fetch_start busy=%b req=%b addr=%h exp 1 1 00", busy, imem_req, imem_addr); else n_pass++;
        run_instr(c);
        n_checks++; if (c !== 4 || pc !== 8'h01) $display("FAIL li_r2 cyc=%0d pc=%h exp 4 01", c, pc); else n_pass++;
        run_instr(c);
        n_checks++; if (c !== 4 || pc !== 8'h02) $display("FAIL li_r1 cyc=%0d pc=%h exp 4 02", c, pc); else n_pass++;
        run_instr(c);
        n_checks++; if (c !== 4 || pc !== 8'h03) $display("FAIL add_cyc cyc=%0d pc=%h exp 4 03", c, pc); else n_pass++;
        n_checks++; if (alu_in0 !== 8'h01 || alu_in1 !== 8'h02 || alu_instruction !== 8'h16 || alu_pc !== 8'h02)
            $display("FAIL add_operands got %h %h %h %h exp 01 02 16 02", alu_in0, alu_in1, alu_instruction, alu_pc); else n_pass++;
        run_instr(c);
        n_checks++; if (alu_in0 !== 8'h03) $display("FAIL add_result got %h exp 03", alu_in0); else n_pass++;
    endtask

    task automatic test_overflow();
        int c;
        do_reset();
        dmem[0] = 8'h7F;
        prog[0] = 8'hA0; prog[1] = 8'hF5; prog[2] = 8'h11; prog[3] = 8'h31; prog[4] = 8'h00;
        start_pulse();
        run_instr(c);
        n_checks++; if (c !== 5) $display("FAIL lw_cyc got %0d exp 5", c); else n_pass++;
        run_instr(c);
        n_checks++; if (ovf_sticky !== 1'b0) $display("FAIL ovf_pre got %b exp 0", ovf_sticky); else n_pass++;
        run_instr(c);
        n_checks++; if (ovf_sticky !== 1'b1) $display("FAIL ovf_add got %b exp 1", ovf_sticky); else n_pass++;
        run_instr(c);
        n_checks++; if (alu_in0 !== 8'h80 || ovf_sticky !== 1'b1)
            $display("FAIL ovf_and r0=%h ovf=%b exp 80 1", alu_in0, ovf_sticky); else n_pass++;
    endtask

    task automatic test_lw_wait();
        int c, bad_i, bad_d;
        do_reset();
        idelay = 3; ddelay = 2;
        dmem[0] = 8'hC3;
        prog[0] = 8'hA6; prog[1] = 8'h04;
        start_pulse();
        bad_i = 0; bad_d = 0;
        for (int i = 0; i < 10; i++) begin
            if (imem_req !== (i < 4)) bad_i++;
            if (i < 4 && imem_addr !== 8'h00) bad_i++;
            if (dmem_req !== (i >= 6 && i <= 8)) bad_d++;
            if (i >= 6 && i <= 8 && (dmem_we !== 1'b0 || dmem_addr !== 8'h00)) bad_d++;
            step();
        end
        n_checks++; if (bad_i !== 0) $display("FAIL lw_imem_hold got %0d bad cycles exp 0", bad_i); else n_pass++;
        n_checks++; if (bad_d !== 0) $display("FAIL lw_dmem_hold got %0d bad cycles exp 0", bad_d); else n_pass++;
        n_checks++; if (imem_req !== 1'b1 || pc !== 8'h01) $display("FAIL lw_10cyc req=%b pc=%h exp 1 01", imem_req, pc); else n_pass++;
        run_instr(c);
        n_checks++; if (alu_in0 !== 8'hC3 || c !== 7) $display("FAIL lw_data r1=%h cyc=%0d exp c3 7", alu_in0, c); else n_pass++;
    endtask

    task automatic test_branch();
        int c;
        do_reset();
        dmem[0] = 8'h40;
        prog[0] = 8'hAC; prog[1] = 8'hC1; prog[8'h40] = 8'hF5; prog[8'h41] = 8'hC1;
        start_pulse();
        run_instr(c);
        run_instr(c);
        n_checks++; if (pc !== 8'h40 || c !== 4) $display("FAIL beq_taken pc=%h cyc=%0d exp 40 4", pc, c); else n_pass++;
        run_instr(c);
        run_instr(c);
        n_checks++; if (pc !== 8'h42) $display("FAIL beq_not_taken pc=%h exp 42", pc); else n_pass++;
    endtask

    task automatic test_jal_halt();
        int c;
        do_reset();
        dmem[0] = 8'h10;
        prog[0] = 8'hA4; prog[1] = 8'h81; prog[8'h10] = 8'h91;
        start_pulse();
        run_instr(c);
        run_instr(c);
        n_checks++; if (pc !== 8'h10) $display("FAIL jmp_pc got %h exp 10", pc); else n_pass++;
        run_instr(c);
        n_checks++; if (halted !== 1'b1 || busy !== 1'b0 || pc !== 8'h10)
            $display("FAIL jal_halt halted=%b busy=%b pc=%h exp 1 0 10", halted, busy, pc); else n_pass++;
        n_checks++; if (dut.rf_q[3] !== 8'h11) $display("FAIL jal_link got %h exp 11", dut.rf_q[3]); else n_pass++;
        start_pulse();
        repeat (3) step();
        n_checks++; if (halted !== 1'b1 || imem_req !== 1'b0 || pc !== 8'h10)
            $display("FAIL halt_sticky halted=%b req=%b pc=%h exp 1 0 10", halted, imem_req, pc); else n_pass++;
    endtask

    task automatic test_timeout();
        int bad, c;
        do_reset();
        dead_addr = 0;
        start_pulse();
        bad = 0;
        for (int i = 0; i < MEM_TIMEOUT; i++) begin
            if (error !== 1'b0 || imem_req !== 1'b1) bad++;
            step();
        end
        n_checks++; if (bad !== 0) $display("FAIL timeout_early got %0d bad cycles exp 0", bad); else n_pass++;
        n_checks++; if (error !== 1'b1 || busy !== 1'b0 || imem_req !== 1'b0)
            $display("FAIL timeout_error err=%b busy=%b req=%b exp 1 0 0", error, busy, imem_req); else n_pass++;
        start_pulse();
        repeat (2) step();
        n_checks++; if (error !== 1'b1) $display("FAIL error_sticky got %b exp 1", error); else n_pass++;

        do_reset();
        dead_addr = 3;
        prog[0] = 8'hF5; prog[1] = 8'hF5; prog[2] = 8'hF5;
        start_pulse();
        for (int i = 0; i < 3; i++) run_instr(c);
        repeat (3) step();
        n_checks++; if (pc !== 8'h03 || imem_req !== 1'b1) $display("FAIL midfetch_pre pc=%h req=%b exp 03 1", pc, imem_req); else n_pass++;
        reset = 1'b1;
        step();
        n_checks++; if (imem_req !== 1'b0 || pc !== RESET_PC || busy !== 1'b0)
            $display("FAIL midfetch_reset req=%b pc=%h busy=%b exp 0 %h 0", imem_req, pc, busy, RESET_PC); else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_random();
        int c, ce, bad;
        bit he;
        logic [7:0] ins, pc0, a0, b0;
        for (int run = 0; run < 4; run++) begin
            do_reset();
            for (int i = 0; i < 256; i++) begin
                prog[i] = 8'($urandom);
                dmem[i] = 8'($urandom);
                mmem[i] = dmem[i];
            end
            idelay = $urandom_range(0, 3);
            ddelay = $urandom_range(0, 3);
            for (int i = 0; i < 4; i++) mR[i] = 8'h00;
            mpc = RESET_PC; movf = 1'b0;
            start_pulse();
            for (int k = 0; k < 30; k++) begin
                pc0 = mpc; ins = prog[mpc];
                a0 = mR[ins[3:2]]; b0 = mR[ins[1:0]];
                model_step(ins, ce, he);
                run_instr(c);
                n_checks++; if (c !== ce) $display("FAIL rnd_cycles run%0d k%0d got %0d exp %0d", run, k, c, ce); else n_pass++;
                n_checks++; if (pc !== mpc) $display("FAIL rnd_pc run%0d k%0d got %h exp %h", run, k, pc, mpc); else n_pass++;
                n_checks++; if (alu_instruction !== ins || alu_pc !== pc0)
                    $display("FAIL rnd_ins run%0d k%0d got %h@%h exp %h@%h", run, k, alu_instruction, alu_pc, ins, pc0); else n_pass++;
                n_checks++; if (alu_in0 !== a0 || alu_in1 !== b0)
                    $display("FAIL rnd_operands run%0d k%0d got %h %h exp %h %h", run, k, alu_in0, alu_in1, a0, b0); else n_pass++;
                n_checks++; if (ovf_sticky !== movf || halted !== he)
                    $display("FAIL rnd_flags run%0d k%0d ovf=%b halt=%b exp %b %b", run, k, ovf_sticky, halted, movf, he); else n_pass++;
                if (he || halted || error) break;
            end
            bad = 0;
            for (int i = 0; i < 256; i++) if (dmem[i] !== mmem[i]) bad++;
            n_checks++; if (bad !== 0) $display("FAIL rnd_dmem run%0d got %0d differing bytes exp 0", run, bad); else n_pass++;
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0;
        idelay = 0; ddelay = 0; dead_addr = -1;
        test_reset();
        test_li_add();
        test_overflow();
        test_lw_wait();
        test_branch();
        test_jal_halt();
        test_timeout();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
